// File: rtl/gf_pkg.sv
// Shared constants and types for the Reed-Solomon decoder blocks.
package gf_pkg;

  localparam int SYMB_WIDTH  = 8;
  localparam int T_LEN       = 4;
  localparam int ROOTS_NUM   = 2 * T_LEN;
  localparam int N_LEN       = 255;

  // Width of the Forney latency down-counter (latency 0..15).
  localparam int FCTRL_CNT_W = 4;
  // Enough bits to hold an error count of 0..T_LEN.
  localparam int ERR_CNT_W   = $clog2(T_LEN + 1);
  // Enough bits to index one of T_LEN error slots.
  localparam int IDX_W       = (T_LEN > 1) ? $clog2(T_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } fctrl_state_t;

  // A valid mask is legal only when its set bits form a run starting at bit 0.
  function automatic logic is_thermo(input logic [T_LEN-1:0] vld);
    logic [T_LEN-1:0] plus_one;
    plus_one = vld + 1'b1;
    return (vld & plus_one) == '0;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] pop_count(input logic [T_LEN-1:0] vld);
    logic [ERR_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < T_LEN; i++) begin
      cnt = cnt + ERR_CNT_W'(vld[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rs_forney_ctrl_stats.sv
// Saturating per-codeword statistics counters for rs_forney_ctrl.
module rs_forney_ctrl_stats
  import gf_pkg::*;
(
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 evt_i,
  input  logic [ERR_CNT_W-1:0] err_cnt_i,
  input  logic                 fail_i,
  output logic [31:0]          stat_cw_o,
  output logic [31:0]          stat_sym_o,
  output logic [31:0]          stat_fail_o
);

  logic [31:0] cw_q,   cw_d;
  logic [31:0] sym_q,  sym_d;
  logic [31:0] fail_q, fail_d;
  logic [32:0] sym_sum;

  // Next-state: saturating increments on each completed codeword.
  always_comb begin
    cw_d    = cw_q;
    sym_d   = sym_q;
    fail_d  = fail_q;
    sym_sum = {1'b0, sym_q} + 33'(err_cnt_i);
    if (evt_i) begin
      if (cw_q != '1) cw_d = cw_q + 1'b1;
      sym_d = sym_sum[32] ? '1 : sym_sum[31:0];
      if (fail_i && (fail_q != '1)) fail_d = fail_q + 1'b1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cw_q   <= '0;
      sym_q  <= '0;
      fail_q <= '0;
    end else begin
      cw_q   <= cw_d;
      sym_q  <= sym_d;
      fail_q <= fail_d;
    end
  end

  assign stat_cw_o   = cw_q;
  assign stat_sym_o  = sym_q;
  assign stat_fail_o = fail_q;

endmodule

// File: rtl/rs_forney_ctrl.sv
// Forney stage controller: registers one decode job into the external Forney
// datapath, waits FORNEY_LAT cycles, then streams one correction beat per
// error (or a single pass/fail beat). Optional statistics counters are built
// when RS_FORNEY_CTRL_STATS_EN is defined.
module rs_forney_ctrl
  import gf_pkg::*;
#(
  parameter int FORNEY_LAT = 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SYMB_WIDTH-1:0] in_err_pos [T_LEN],
  input  logic [T_LEN-1:0]      in_err_pos_vld,
  input  logic [SYMB_WIDTH-1:0] in_syndrome [ROOTS_NUM],
  output logic [SYMB_WIDTH-1:0] fy_error_positions [T_LEN],
  output logic [T_LEN-1:0]      fy_error_positions_vld,
  output logic [SYMB_WIDTH-1:0] fy_syndrome [ROOTS_NUM],
  output logic                  fy_syndrome_vld,
  input  logic [SYMB_WIDTH-1:0] fy_magnitude [T_LEN],
  input  logic                  fy_irq,
  output logic                  corr_valid,
  input  logic                  corr_ready,
  output logic [SYMB_WIDTH-1:0] corr_pos,
  output logic [SYMB_WIDTH-1:0] corr_mag,
  output logic                  corr_last,
`ifdef RS_FORNEY_CTRL_STATS_EN
  output logic [31:0]           stat_cw,
  output logic [31:0]           stat_sym,
  output logic [31:0]           stat_fail,
`endif
  output logic                  corr_fail
);

  fctrl_state_t           state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic [SYMB_WIDTH-1:0]  fy_err_pos_q [T_LEN];
  logic [SYMB_WIDTH-1:0]  fy_err_pos_d [T_LEN];
  logic [T_LEN-1:0]       fy_err_vld_q, fy_err_vld_d;
  logic [SYMB_WIDTH-1:0]  fy_synd_q [ROOTS_NUM];
  logic [SYMB_WIDTH-1:0]  fy_synd_d [ROOTS_NUM];
  logic                   fy_synd_vld_q, fy_synd_vld_d;
  logic [FCTRL_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [SYMB_WIDTH-1:0]  mag_q [T_LEN];
  logic [SYMB_WIDTH-1:0]  mag_d [T_LEN];
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   corr_valid_q, corr_valid_d;
  logic [SYMB_WIDTH-1:0]  corr_pos_q, corr_pos_d;
  logic [SYMB_WIDTH-1:0]  corr_mag_q, corr_mag_d;
  logic                   corr_last_q, corr_last_d;
  logic                   corr_fail_q, corr_fail_d;

  logic                   fail_c;
  logic [ERR_CNT_W-1:0]   nerr_c;
  logic [IDX_W-1:0]       nxt_idx_c;

  // Next-state and output-register logic for the IDLE/CALC/EMIT sequencer.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d       = state_q;
    in_ready_d    = in_ready_q;
    fy_err_pos_d  = fy_err_pos_q;
    fy_err_vld_d  = fy_err_vld_q;
    fy_synd_d     = fy_synd_q;
    fy_synd_vld_d = 1'b0;
    lat_cnt_d     = lat_cnt_q;
    mag_d         = mag_q;
    err_cnt_d     = err_cnt_q;
    idx_d         = idx_q;
    corr_valid_d  = corr_valid_q;
    corr_pos_d    = corr_pos_q;
    corr_mag_d    = corr_mag_q;
    corr_last_d   = corr_last_q;
    corr_fail_d   = corr_fail_q;
    fail_c        = fy_irq | ~is_thermo(fy_err_vld_q);
    nerr_c        = pop_count(fy_err_vld_q);
    nxt_idx_c     = idx_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          fy_err_pos_d  = in_err_pos;
          fy_err_vld_d  = in_err_pos_vld;
          fy_synd_d     = in_syndrome;
          fy_synd_vld_d = 1'b1;
          lat_cnt_d     = FCTRL_CNT_W'(FORNEY_LAT);
          in_ready_d    = 1'b0;
          state_d       = CALC;
        end
      end

      CALC: begin
        if (lat_cnt_q == '0) begin
          // Datapath result is valid this cycle: capture and present beat 0.
          mag_d        = fy_magnitude;
          err_cnt_d    = fail_c ? '0 : nerr_c;
          idx_d        = '0;
          corr_valid_d = 1'b1;
          if (fail_c || (nerr_c == '0)) begin
            corr_pos_d  = '0;
            corr_mag_d  = '0;
            corr_last_d = 1'b1;
            corr_fail_d = fail_c;
          end else begin
            corr_pos_d  = fy_err_pos_q[0];
            corr_mag_d  = fy_magnitude[0];
            corr_last_d = (nerr_c == ERR_CNT_W'(1));
            corr_fail_d = 1'b0;
          end
          state_d = EMIT;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end

      EMIT: begin
        if (corr_valid_q && corr_ready) begin
          if (corr_last_q) begin
            corr_valid_d = 1'b0;
            corr_pos_d   = '0;
            corr_mag_d   = '0;
            corr_last_d  = 1'b0;
            corr_fail_d  = 1'b0;
            in_ready_d   = 1'b1;
            state_d      = IDLE;
          end else begin
            idx_d       = nxt_idx_c;
            corr_pos_d  = fy_err_pos_q[nxt_idx_c];
            corr_mag_d  = mag_q[nxt_idx_c];
            corr_last_d = ((ERR_CNT_W'(idx_q) + ERR_CNT_W'(2)) == err_cnt_q);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any job in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      fy_err_pos_q  <= '{default: '0};
      fy_err_vld_q  <= '0;
      fy_synd_q     <= '{default: '0};
      fy_synd_vld_q <= 1'b0;
      lat_cnt_q     <= '0;
      // NOTE: the magnitude capture array is tiny, so it is reset along with
      // the rest rather than left uninitialised like a true memory would be.
      mag_q         <= '{default: '0};
      err_cnt_q     <= '0;
      idx_q         <= '0;
      corr_valid_q  <= 1'b0;
      corr_pos_q    <= '0;
      corr_mag_q    <= '0;
      corr_last_q   <= 1'b0;
      corr_fail_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      fy_err_pos_q  <= fy_err_pos_d;
      fy_err_vld_q  <= fy_err_vld_d;
      fy_synd_q     <= fy_synd_d;
      fy_synd_vld_q <= fy_synd_vld_d;
      lat_cnt_q     <= lat_cnt_d;
      mag_q         <= mag_d;
      err_cnt_q     <= err_cnt_d;
      idx_q         <= idx_d;
      corr_valid_q  <= corr_valid_d;
      corr_pos_q    <= corr_pos_d;
      corr_mag_q    <= corr_mag_d;
      corr_last_q   <= corr_last_d;
      corr_fail_q   <= corr_fail_d;
    end
  end

  assign in_ready               = in_ready_q;
  assign fy_error_positions     = fy_err_pos_q;
  assign fy_error_positions_vld = fy_err_vld_q;
  assign fy_syndrome            = fy_synd_q;
  assign fy_syndrome_vld        = fy_synd_vld_q;
  assign corr_valid             = corr_valid_q;
  assign corr_pos               = corr_pos_q;
  assign corr_mag               = corr_mag_q;
  assign corr_last              = corr_last_q;
  assign corr_fail              = corr_fail_q;

`ifdef RS_FORNEY_CTRL_STATS_EN
  logic last_hs;
  assign last_hs = (state_q == EMIT) && corr_valid_q && corr_ready && corr_last_q;

  rs_forney_ctrl_stats u_stats (
    .aclk        (aclk),
    .areset      (areset),
    .evt_i       (last_hs),
    .err_cnt_i   (err_cnt_q),
    .fail_i      (corr_fail_q),
    .stat_cw_o   (stat_cw),
    .stat_sym_o  (stat_sym),
    .stat_fail_o (stat_fail)
  );
`endif

endmodule

// File: tb/tb_rs_forney_ctrl.sv
// Directed self-checking bench for rs_forney_ctrl with FORNEY_LAT=2 and a
// simple Forney datapath model that drives magnitudes only in the valid cycle.
module tb_rs_forney_ctrl;
  import gf_pkg::*;

  localparam int LAT = 2;

  logic                  aclk = 1'b0;
  logic                  areset;
  logic                  in_valid;
  logic                  in_ready;
  logic [SYMB_WIDTH-1:0] in_err_pos [T_LEN];
  logic [T_LEN-1:0]      in_err_pos_vld;
  logic [SYMB_WIDTH-1:0] in_syndrome [ROOTS_NUM];
  logic [SYMB_WIDTH-1:0] fy_error_positions [T_LEN];
  logic [T_LEN-1:0]      fy_error_positions_vld;
  logic [SYMB_WIDTH-1:0] fy_syndrome [ROOTS_NUM];
  logic                  fy_syndrome_vld;
  logic [SYMB_WIDTH-1:0] fy_magnitude [T_LEN];
  logic                  fy_irq;
  logic                  corr_valid;
  logic                  corr_ready;
  logic [SYMB_WIDTH-1:0] corr_pos;
  logic [SYMB_WIDTH-1:0] corr_mag;
  logic                  corr_last;
  logic                  corr_fail;
`ifdef RS_FORNEY_CTRL_STATS_EN
  logic [31:0]           stat_cw;
  logic [31:0]           stat_sym;
  logic [31:0]           stat_fail;
`endif

  // Job stimulus and hand-written expectations.
  logic [T_LEN-1:0]      job_vld;
  logic [SYMB_WIDTH-1:0] job_pos [T_LEN];
  logic [SYMB_WIDTH-1:0] job_mag [T_LEN];
  logic                  job_irq;
  int                    exp_n;
  logic [SYMB_WIDTH-1:0] exp_pos [T_LEN];
  logic [SYMB_WIDTH-1:0] exp_mag [T_LEN];
  logic                  exp_fail;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 aclk = ~aclk;

  rs_forney_ctrl #(.FORNEY_LAT(LAT)) dut (
    .aclk                   (aclk),
    .areset                 (areset),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .in_err_pos             (in_err_pos),
    .in_err_pos_vld         (in_err_pos_vld),
    .in_syndrome            (in_syndrome),
    .fy_error_positions     (fy_error_positions),
    .fy_error_positions_vld (fy_error_positions_vld),
    .fy_syndrome            (fy_syndrome),
    .fy_syndrome_vld        (fy_syndrome_vld),
    .fy_magnitude           (fy_magnitude),
    .fy_irq                 (fy_irq),
    .corr_valid             (corr_valid),
    .corr_ready             (corr_ready),
    .corr_pos               (corr_pos),
    .corr_mag               (corr_mag),
    .corr_last              (corr_last),
`ifdef RS_FORNEY_CTRL_STATS_EN
    .stat_cw                (stat_cw),
    .stat_sym               (stat_sym),
    .stat_fail              (stat_fail),
`endif
    .corr_fail              (corr_fail)
  );

  // Forney datapath model: results are valid exactly LAT cycles after the
  // syndrome-valid cycle and are junk (0xEE, irq=0) at all other times.
  logic [LAT-1:0] dly;
  always @(posedge aclk or posedge areset) begin
    if (areset) dly <= '0;
    else        dly <= {dly[LAT-2:0], fy_syndrome_vld};
  end

  always_comb begin
    for (int i = 0; i < T_LEN; i++) fy_magnitude[i] = dly[LAT-1] ? job_mag[i] : 8'hEE;
    fy_irq = dly[LAT-1] & job_irq;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [SYMB_WIDTH-1:0] synd_val(input int i);
    return 8'(i * 17) ^ job_pos[0];
  endfunction

  // Offer the job, wait for acceptance, and return at the negedge of the
  // cycle after acceptance (the syndrome-valid cycle).
  task automatic start_job(input string tag, input bit hold);
    int w;
    @(negedge aclk);
    for (int i = 0; i < T_LEN; i++) in_err_pos[i] = job_pos[i];
    for (int i = 0; i < ROOTS_NUM; i++) in_syndrome[i] = synd_val(i);
    in_err_pos_vld = job_vld;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge aclk);
      w++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge aclk);
    @(negedge aclk);
    if (!hold) in_valid = 1'b0;
    check({tag, "_syn_vld"}, 32'(fy_syndrome_vld), 32'd1);
    check({tag, "_fy_vld"}, 32'(fy_error_positions_vld), 32'(job_vld));
    check({tag, "_fy_pos0"}, 32'(fy_error_positions[0]), 32'(job_pos[0]));
    check({tag, "_fy_syn7"}, 32'(fy_syndrome[7]), 32'(synd_val(7)));
  endtask

  // Collect correction beats starting from the syndrome-valid cycle (k=1).
  // The first 'stall' cycles with a visible beat are back-pressured.
  task automatic finish_job(input string tag, input int stall);
    int k = 1;
    int b = 0;
    int first = -1;
    int st = stall;
    bit done = 1'b0;
    bit busy_bad = 1'b0;
    bit pos_stable = 1'b1;
    logic [SYMB_WIDTH-1:0] held_pos;
    while (!done && k < 60) begin
      @(negedge aclk);
      k++;
      if (k == 2) check({tag, "_syn_pulse"}, 32'(fy_syndrome_vld), 32'd0);
      if (in_ready) busy_bad = 1'b1;
      if (fy_error_positions_vld !== job_vld) pos_stable = 1'b0;
      if (corr_valid) begin
        if (first < 0) first = k;
        if (st > 0) begin
          corr_ready = 1'b0;
          st--;
        end else begin
          corr_ready = 1'b1;
        end
        if (b < exp_n) begin
          check({tag, "_beat"}, {8'h00, corr_pos, corr_mag, 6'b0, corr_last, corr_fail},
                {8'h00, exp_pos[b], exp_mag[b], 6'b0, (b == exp_n - 1) ? 1'b1 : 1'b0, exp_fail});
        end else begin
          check({tag, "_extra_beat"}, 32'(b), 32'(exp_n - 1));
        end
        if (corr_ready) begin
          if (corr_last) done = 1'b1;
          b++;
        end
      end
    end
    held_pos = corr_pos;
    corr_ready = 1'b1;
    check({tag, "_latency"}, 32'(first), 32'(LAT + 2));
    check({tag, "_beats"}, 32'(b), 32'(exp_n));
    check({tag, "_busy_ready"}, 32'(busy_bad), 32'd0);
    check({tag, "_fy_stable"}, 32'(pos_stable), 32'd1);
    @(negedge aclk);
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_valid_after"}, 32'(corr_valid), 32'd0);
  endtask

  initial begin
    int w;
    int extra;
    areset = 1'b1;
    in_valid = 1'b0;
    corr_ready = 1'b1;
    in_err_pos_vld = '0;
    for (int i = 0; i < T_LEN; i++) in_err_pos[i] = '0;
    for (int i = 0; i < ROOTS_NUM; i++) in_syndrome[i] = '0;
    job_vld = '0; job_irq = 1'b0;
    job_pos = '{8'd0, 8'd0, 8'd0, 8'd0};
    job_mag = '{8'd0, 8'd0, 8'd0, 8'd0};

    // Reset state.
    repeat (3) @(negedge aclk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_corr_valid", 32'(corr_valid), 32'd0);
    check("rst_syn_vld", 32'(fy_syndrome_vld), 32'd0);
    areset = 1'b0;
    @(negedge aclk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Two errors, no back-pressure.
    job_vld = 4'b0011; job_irq = 1'b0;
    job_pos = '{8'd5, 8'd9, 8'd0, 8'd0};
    job_mag = '{8'h1A, 8'h3C, 8'h00, 8'h00};
    exp_n = 2; exp_fail = 1'b0;
    exp_pos = '{8'd5, 8'd9, 8'd0, 8'd0};
    exp_mag = '{8'h1A, 8'h3C, 8'h00, 8'h00};
    start_job("two", 1'b0);
    finish_job("two", 0);

    // Zero errors.
    job_vld = 4'b0000; job_irq = 1'b0;
    job_pos = '{8'h12, 8'h34, 8'h56, 8'h78};
    job_mag = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
    exp_n = 1; exp_fail = 1'b0;
    exp_pos = '{8'd0, 8'd0, 8'd0, 8'd0};
    exp_mag = '{8'd0, 8'd0, 8'd0, 8'd0};
    start_job("zero", 1'b0);
    finish_job("zero", 0);

    // Zero-derivative flag at capture.
    job_vld = 4'b0011; job_irq = 1'b1;
    job_pos = '{8'd7, 8'd8, 8'd0, 8'd0};
    job_mag = '{8'h55, 8'h66, 8'h00, 8'h00};
    exp_n = 1; exp_fail = 1'b1;
    start_job("irq", 1'b0);
    finish_job("irq", 0);
`ifdef RS_FORNEY_CTRL_STATS_EN
    check("stat_cw", stat_cw, 32'd3);
    check("stat_sym", stat_sym, 32'd2);
    check("stat_fail", stat_fail, 32'd1);
`endif

    // Non-thermometer valid mask.
    job_vld = 4'b0101; job_irq = 1'b0;
    job_pos = '{8'd4, 8'd6, 8'd8, 8'd10};
    job_mag = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp_n = 1; exp_fail = 1'b1;
    start_job("nonthermo", 1'b0);
    finish_job("nonthermo", 0);

    // Four errors with 3 cycles of back-pressure on the first beat.
    job_vld = 4'b1111; job_irq = 1'b0;
    job_pos = '{8'd3, 8'd17, 8'd40, 8'd200};
    job_mag = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_n = 4; exp_fail = 1'b0;
    exp_pos = '{8'd3, 8'd17, 8'd40, 8'd200};
    exp_mag = '{8'h11, 8'h22, 8'h33, 8'h44};
    start_job("stall", 1'b0);
    finish_job("stall", 3);

    // Reset during EMIT after the first beat handshake.
    job_vld = 4'b0011; job_irq = 1'b0;
    job_pos = '{8'd5, 8'd9, 8'd0, 8'd0};
    job_mag = '{8'h1A, 8'h3C, 8'h00, 8'h00};
    start_job("rst_job", 1'b0);
    w = 0;
    while (!corr_valid && w < 20) begin
      @(negedge aclk);
      w++;
    end
    check("rst_job_beat1_pos", 32'(corr_pos), 32'd5);
    @(negedge aclk);
    check("rst_job_beat2_pos", 32'(corr_pos), 32'd9);
    areset = 1'b1;
    #1;
    check("mid_rst_corr_valid", 32'(corr_valid), 32'd0);
    check("mid_rst_corr_pos", 32'(corr_pos), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_fy_vld", 32'(fy_error_positions_vld), 32'd0);
    check("mid_rst_fy_pos0", 32'(fy_error_positions[0]), 32'd0);
`ifdef RS_FORNEY_CTRL_STATS_EN
    check("mid_rst_stat_cw", stat_cw, 32'd0);
`endif
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge aclk);
      if (corr_valid) extra++;
    end
    check("post_rst_no_beats", 32'(extra), 32'd0);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Normal job after reset; input held valid through the job so a second
    // offer is queued and must be taken right after return to IDLE.
    job_vld = 4'b0001; job_irq = 1'b0;
    job_pos = '{8'd77, 8'd0, 8'd0, 8'd0};
    job_mag = '{8'h5A, 8'h00, 8'h00, 8'h00};
    exp_n = 1; exp_fail = 1'b0;
    exp_pos = '{8'd77, 8'd0, 8'd0, 8'd0};
    exp_mag = '{8'h5A, 8'h00, 8'h00, 8'h00};
    start_job("after_rst", 1'b1);
    finish_job("after_rst", 0);
    @(posedge aclk);
    @(negedge aclk);
    in_valid = 1'b0;
    check("queued_accept", 32'(fy_syndrome_vld), 32'd1);
    finish_job("queued", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rs_forney_ctrl.md
RS_FORNEY_CTRL -- requirements
Module: rs_forney_ctrl

Interface
REQ-001 SHALL take parameter FORNEY_LAT, default 1: cycles from fy_syndrome_vld to valid fy_magnitude, legal range 0..15.
REQ-002 SHALL take SYMB_WIDTH, T_LEN, ROOTS_NUM and N_LEN from gf_pkg; they are not module parameters.
REQ-003 aclk  in  1  the single clock; all logic is on its rising edge.
REQ-004 areset  in  1  asynchronous, active-high reset.
REQ-005 in_valid / in_ready  in / out  1 / 1  handshake for one codeword's decode job.
REQ-006 in_err_pos[T_LEN]  in  SYMB_WIDTH each  error positions from Chien search.
REQ-007 in_err_pos_vld  in  T_LEN  per-position valid; legal only as thermometer from bit 0.
REQ-008 in_syndrome[ROOTS_NUM]  in  SYMB_WIDTH each  syndrome of the codeword.
REQ-009 fy_error_positions[T_LEN], fy_error_positions_vld, fy_syndrome[ROOTS_NUM], fy_syndrome_vld  out  as inputs  registered drive to the Forney datapath.
REQ-010 fy_magnitude[T_LEN]  in  SYMB_WIDTH each  magnitudes returned by the Forney datapath.
REQ-011 fy_irq  in  1  Forney zero-derivative error flag.
REQ-012 corr_valid / corr_ready  out / in  1 / 1  correction stream handshake.
REQ-013 corr_pos, corr_mag  out  SYMB_WIDTH each  position to correct and the XOR value to apply.
REQ-014 corr_last, corr_fail  out  1 each  last beat of the codeword; decode failure flag.

Function
REQ-015 FSM states SHALL be IDLE, CALC, EMIT.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready register all inputs into fy_* and go to CALC.
REQ-017 fy_syndrome_vld SHALL pulse exactly one cycle, the cycle after acceptance.
REQ-018 All other fy_* outputs SHALL hold stable from acceptance until return to IDLE.
REQ-019 CALC: a down-counter loaded with FORNEY_LAT expires; fy_magnitude, fy_irq and the error count are captured FORNEY_LAT cycles after the fy_syndrome_vld cycle; then go to EMIT.
REQ-020 First corr_valid SHALL rise the cycle after capture, giving acceptance-to-first-beat latency FORNEY_LAT+2.
REQ-021 EMIT: one beat per set bit of fy_error_positions_vld, in ascending index order: corr_pos=fy_error_positions[i], corr_mag=captured magnitude[i], corr_fail=0.
REQ-022 A beat SHALL advance only on corr_valid&corr_ready; corr_pos, corr_mag, corr_last and corr_fail SHALL hold while corr_valid&~corr_ready (back-pressure).
REQ-023 corr_last=1 on the final beat; after its handshake go to IDLE, with in_ready=1 the next cycle (no same-cycle re-accept).
REQ-024 Zero errors: exactly one beat: pos=0, mag=0, last=1, fail=0.
REQ-025 Failure (captured fy_irq=1, or non-thermometer vld): exactly one beat: pos=0, mag=0, last=1, fail=1.
REQ-026 in_ready SHALL be 0 in CALC and EMIT.
REQ-027 An input offered during CALC or EMIT SHALL NOT be lost; it is accepted after return to IDLE.

Reset
REQ-028 areset SHALL force IDLE and clear every output: in_ready=0 during reset and 1 the first cycle after; corr_*=0; fy_*=0.
REQ-029 Reset mid-CALC or mid-EMIT SHALL abandon the job; no partial beats are produced after release.

Configuration
REQ-030 With RS_FORNEY_CTRL_STATS_EN defined, the block SHALL add outputs stat_cw, stat_sym and stat_fail, each 32 bits, saturating, cleared by areset.
REQ-031 The counters SHALL increment on the last-beat handshake: stat_cw by 1, stat_sym by the error count, stat_fail by 1 when fail=1.
REQ-032 Without RS_FORNEY_CTRL_STATS_EN, the ports and logic SHALL be absent and function SHALL be identical.

Structure
REQ-033 gf_pkg SHALL hold the FSM state enum typedef fctrl_state_t and the FCTRL_CNT_W=4 constant.
REQ-034 The counters SHALL live in sub-module rs_forney_ctrl_stats, instantiated only under the macro.
REQ-035 The Forney datapath SHALL be external and port-connected, not instantiated inside this block.

Verification (T_LEN=4, SYMB_WIDTH=8, FORNEY_LAT=2)
REQ-036 vld=4'b0011, pos={5,9}, magnitudes {0x1A,0x3C}, corr_ready=1 -> first beat 4 cycles after acceptance: (5,0x1A,last0), then (9,0x3C,last1).
REQ-037 vld=4'b0000 -> single beat pos0/mag0/last1/fail0.
REQ-038 fy_irq=1 at capture -> single beat fail=1, last=1; with macro, stat_fail=1.
REQ-039 vld=4'b0101 -> single fail beat.
REQ-040 corr_ready low 3 cycles on beat 1 of a 4-error job -> beat held stable, 4 beats total, in_ready stays 0 until the last handshake.
REQ-041 areset pulsed during EMIT after beat 1 -> outputs cleared, no further beats, next job decodes normally.
